// File: rtl/alu_pkg.sv
// Shared constants for the ALU control / MDU slice: ALUOp classes, funct codes, ALU op codes, MDU FSM states.
package alu_pkg;

    localparam logic [2:0] ALUOP_LWSW   = 3'b000;
    localparam logic [2:0] ALUOP_ORI    = 3'b001;
    localparam logic [2:0] ALUOP_ANDI   = 3'b010;
    localparam logic [2:0] ALUOP_ADDI   = 3'b011;
    localparam logic [2:0] ALUOP_BRANCH = 3'b100;
    localparam logic [2:0] ALUOP_LUI    = 3'b101;
    localparam logic [2:0] ALUOP_RTYPE  = 3'b111;

    localparam logic [5:0] FN_SLL   = 6'h00;
    localparam logic [5:0] FN_SRL   = 6'h02;
    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_MFHI  = 6'h10;
    localparam logic [5:0] FN_MFLO  = 6'h12;
    localparam logic [5:0] FN_MULT  = 6'h18;
    localparam logic [5:0] FN_MULTU = 6'h19;
    localparam logic [5:0] FN_DIV   = 6'h1A;
    localparam logic [5:0] FN_DIVU  = 6'h1B;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_NOR   = 6'h27;

    localparam logic [3:0] OP_AND     = 4'b0000;
    localparam logic [3:0] OP_OR      = 4'b0001;
    localparam logic [3:0] OP_NOR     = 4'b0010;
    localparam logic [3:0] OP_ADD     = 4'b0011;
    localparam logic [3:0] OP_SUB     = 4'b0100;
    localparam logic [3:0] OP_LUI     = 4'b0101;
    localparam logic [3:0] OP_SLL     = 4'b0110;
    localparam logic [3:0] OP_SRL     = 4'b0111;
    localparam logic [3:0] OP_PASS_HI = 4'b1000;
    localparam logic [3:0] OP_PASS_LO = 4'b1001;
    localparam logic [3:0] OP_NOP     = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } mdu_state_t;

endpackage

// File: rtl/alu_control_mdu_if.sv
// Decode-stage bus between main control / register file and the ALU control + MDU block.
interface alu_control_mdu_if #(
    parameter int DATA_WIDTH  = 32,
    parameter int ALUOP_WIDTH = 3,
    parameter int CTRL_WIDTH  = 4
);
    logic [ALUOP_WIDTH-1:0] ALUOp;
    logic [5:0]             ALUFunction;
    logic                   valid_i;
    logic [DATA_WIDTH-1:0]  operand_a;
    logic [DATA_WIDTH-1:0]  operand_b;
    logic [CTRL_WIDTH-1:0]  ALUOperation;
    logic                   stall_o;
    logic [DATA_WIDTH-1:0]  hi_o;
    logic [DATA_WIDTH-1:0]  lo_o;
    logic                   md_done_o;
    logic                   div_by_zero_o;

    modport master (
        output ALUOp, ALUFunction, valid_i, operand_a, operand_b,
        input  ALUOperation, stall_o, hi_o, lo_o, md_done_o, div_by_zero_o
    );

    modport slave (
        input  ALUOp, ALUFunction, valid_i, operand_a, operand_b,
        output ALUOperation, stall_o, hi_o, lo_o, md_done_o, div_by_zero_o
    );
endinterface

// File: rtl/mdu_iter.sv
// Iterative multiply (shift-add) / restoring divide with HI/LO; start edge + DATA_WIDTH iterations + 1 DONE cycle.
// No backpressure: o_busy is high from the start edge until HI/LO are committed.
module mdu_iter
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_start,
    input  logic                  i_is_div,
    input  logic                  i_signed,
    input  logic [DATA_WIDTH-1:0] i_a,
    input  logic [DATA_WIDTH-1:0] i_b,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_div_by_zero,
    output logic [DATA_WIDTH-1:0] o_hi,
    output logic [DATA_WIDTH-1:0] o_lo
);
    localparam int CW = $clog2(DATA_WIDTH);

    mdu_state_t              r_state, w_next;
    logic [CW-1:0]           r_cnt;
    logic [DATA_WIDTH-1:0]   r_acc, r_q, r_m, r_a, r_hi, r_lo;
    logic                    r_is_div, r_dbz, r_neg_q, r_neg_r;

    logic [DATA_WIDTH-1:0]   w_a_mag, w_b_mag;
    logic [DATA_WIDTH:0]     w_mul_sum, w_div_shift, w_div_diff;
    logic [2*DATA_WIDTH-1:0] w_prod, w_prod_fix;

    assign w_a_mag = (i_signed && i_a[DATA_WIDTH-1]) ? -i_a : i_a;
    assign w_b_mag = (i_signed && i_b[DATA_WIDTH-1]) ? -i_b : i_b;

    assign w_mul_sum   = {1'b0, r_acc} + (r_q[0] ? {1'b0, r_m} : '0);
    assign w_div_shift = {r_acc, r_q[DATA_WIDTH-1]};
    assign w_div_diff  = w_div_shift - {1'b0, r_m};
    assign w_prod      = {r_acc, r_q};
    assign w_prod_fix  = r_neg_q ? -w_prod : w_prod;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= ST_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (i_start) w_next = i_is_div ? ST_DIV : ST_MUL;
            ST_MUL:  if (r_cnt == '0) w_next = ST_DONE;
            ST_DIV:  if (r_dbz || r_cnt == '0) w_next = ST_DONE;
            ST_DONE: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt    <= '0;
            r_acc    <= '0;
            r_q      <= '0;
            r_m      <= '0;
            r_a      <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_is_div <= 1'b0;
            r_dbz    <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: if (i_start) begin
                    // Multiply keeps the multiplier in r_q; divide keeps the dividend there.
                    r_cnt    <= CW'(DATA_WIDTH - 1);
                    r_acc    <= '0;
                    r_q      <= i_is_div ? w_a_mag : w_b_mag;
                    r_m      <= i_is_div ? w_b_mag : w_a_mag;
                    r_a      <= i_a;
                    r_is_div <= i_is_div;
                    r_dbz    <= i_is_div && (i_b == '0);
                    r_neg_q  <= i_signed && (i_a[DATA_WIDTH-1] ^ i_b[DATA_WIDTH-1]);
                    r_neg_r  <= i_signed && i_a[DATA_WIDTH-1];
                end
                ST_MUL: begin
                    r_acc <= w_mul_sum[DATA_WIDTH:1];
                    r_q   <= {w_mul_sum[0], r_q[DATA_WIDTH-1:1]};
                    if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
                end
                ST_DIV: if (!r_dbz) begin
                    if (w_div_diff[DATA_WIDTH]) begin
                        r_acc <= w_div_shift[DATA_WIDTH-1:0];
                        r_q   <= {r_q[DATA_WIDTH-2:0], 1'b0};
                    end else begin
                        r_acc <= w_div_diff[DATA_WIDTH-1:0];
                        r_q   <= {r_q[DATA_WIDTH-2:0], 1'b1};
                    end
                    if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
                end
                ST_DONE: begin
                    if (r_dbz) begin
                        r_hi <= r_a;
                        r_lo <= '1;
                    end else if (r_is_div) begin
                        r_hi <= r_neg_r ? -r_acc : r_acc;
                        r_lo <= r_neg_q ? -r_q : r_q;
                    end else begin
                        {r_hi, r_lo} <= w_prod_fix;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_busy        = (r_state != ST_IDLE);
    assign o_done        = (r_state == ST_DONE);
    assign o_div_by_zero = (r_state == ST_DONE) && r_dbz;
    assign o_hi          = r_hi;
    assign o_lo          = r_lo;

endmodule

// File: rtl/alu_control_mdu.sv
// ALU control decode (zero latency) plus HI/LO multiply/divide unit; stalls the front end while the MDU is busy.
// Build option ALU_SIGNED_MDU_EN adds signed MULT/DIV decode.
module alu_control_mdu
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int ALUOP_WIDTH = 3,
    parameter int CTRL_WIDTH  = 4
) (
    input  logic             clk,
    input  logic             reset,
    alu_control_mdu_if.slave bus
);
    logic                  w_rtype, w_mdu_fn, w_is_div, w_signed;
    logic                  w_start, w_busy, w_done, w_dbz, w_pass_hilo, w_hazard;
    logic [3:0]            w_op;
    logic [DATA_WIDTH-1:0] w_hi, w_lo;

    assign w_rtype = (bus.ALUOp == ALUOP_WIDTH'(ALUOP_RTYPE));

    always_comb begin
        w_op = OP_NOP;
        case (bus.ALUOp)
            ALUOP_WIDTH'(ALUOP_LWSW):   w_op = OP_ADD;
            ALUOP_WIDTH'(ALUOP_ORI):    w_op = OP_OR;
            ALUOP_WIDTH'(ALUOP_ANDI):   w_op = OP_AND;
            ALUOP_WIDTH'(ALUOP_ADDI):   w_op = OP_ADD;
            ALUOP_WIDTH'(ALUOP_BRANCH): w_op = OP_SUB;
            ALUOP_WIDTH'(ALUOP_LUI):    w_op = OP_LUI;
            ALUOP_WIDTH'(ALUOP_RTYPE): begin
                case (bus.ALUFunction)
                    FN_ADD:  w_op = OP_ADD;
                    FN_SUB:  w_op = OP_SUB;
                    FN_AND:  w_op = OP_AND;
                    FN_OR:   w_op = OP_OR;
                    FN_NOR:  w_op = OP_NOR;
                    FN_SLL:  w_op = OP_SLL;
                    FN_SRL:  w_op = OP_SRL;
                    FN_MFHI: w_op = OP_PASS_HI;
                    FN_MFLO: w_op = OP_PASS_LO;
                    FN_JR, FN_MULT, FN_MULTU, FN_DIV, FN_DIVU: w_op = OP_NOP;
                    default: w_op = OP_NOP;
                endcase
            end
            default: w_op = OP_NOP;
        endcase
    end

    assign bus.ALUOperation = CTRL_WIDTH'(w_op);

    always_comb begin
        w_mdu_fn = 1'b0;
        w_is_div = 1'b0;
        w_signed = 1'b0;
        if (w_rtype) begin
            case (bus.ALUFunction)
                FN_MULTU: w_mdu_fn = 1'b1;
                FN_DIVU: begin
                    w_mdu_fn = 1'b1;
                    w_is_div = 1'b1;
                end
`ifdef ALU_SIGNED_MDU_EN
                FN_MULT: begin
                    w_mdu_fn = 1'b1;
                    w_signed = 1'b1;
                end
                FN_DIV: begin
                    w_mdu_fn = 1'b1;
                    w_is_div = 1'b1;
                    w_signed = 1'b1;
                end
`endif
                default: ;
            endcase
        end
    end

    // Starts only from IDLE; a start seen while busy is held off by the stall and re-presented.
    assign w_start     = reset && bus.valid_i && w_mdu_fn && !w_busy;
    assign w_pass_hilo = (w_op == OP_PASS_HI) || (w_op == OP_PASS_LO);
    assign w_hazard    = bus.valid_i && w_pass_hilo && w_busy;
    assign bus.stall_o = w_start || w_busy || w_hazard;

    mdu_iter #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_mdu (
        .clk           (clk),
        .reset         (reset),
        .i_start       (w_start),
        .i_is_div      (w_is_div),
        .i_signed      (w_signed),
        .i_a           (bus.operand_a),
        .i_b           (bus.operand_b),
        .o_busy        (w_busy),
        .o_done        (w_done),
        .o_div_by_zero (w_dbz),
        .o_hi          (w_hi),
        .o_lo          (w_lo)
    );

    assign bus.hi_o          = w_hi;
    assign bus.lo_o          = w_lo;
    assign bus.md_done_o     = w_done;
    assign bus.div_by_zero_o = w_dbz;

endmodule

// File: tb/tb_alu_control_mdu.sv
// Directed self-checking bench for alu_control_mdu: decode table, MULTU/DIVU, divide by zero, HI/LO hazard, mid-op reset.
module tb_alu_control_mdu;
    logic clk;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   stalls, dones, dbzs;

    alu_control_mdu_if #(.DATA_WIDTH(32), .ALUOP_WIDTH(3), .CTRL_WIDTH(4)) bus ();

    alu_control_mdu #(
        .DATA_WIDTH  (32),
        .ALUOP_WIDTH (3),
        .CTRL_WIDTH  (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [2:0] op, input logic [5:0] fn, input logic v,
                         input logic [31:0] a, input logic [31:0] b);
        bus.ALUOp       = op;
        bus.ALUFunction = fn;
        bus.valid_i     = v;
        bus.operand_a   = a;
        bus.operand_b   = b;
    endtask

    task automatic dec(input string tag, input logic [2:0] op, input logic [5:0] fn, input logic [3:0] exp);
        @(negedge clk);
        drive(op, fn, 1'b1, 32'd0, 32'd0);
        #1;
        chk(tag, 64'(bus.ALUOperation), 64'(exp));
        chk({tag, "_stall"}, 64'(bus.stall_o), 64'd0);
    endtask

    // Issues an MDU op, then counts stall / done / div-by-zero cycles after the start edge.
    task automatic run_mdu(input string tag, input logic [5:0] fn, input logic [31:0] a,
                           input logic [31:0] b, input int mfhi_at);
        @(negedge clk);
        drive(3'b111, fn, 1'b1, a, b);
        #1;
        chk({tag, "_start_stall"}, 64'(bus.stall_o), 64'd1);
        @(negedge clk);
        drive(3'b111, 6'h20, 1'b0, 32'd0, 32'd0);
        #1;
        stalls = 0;
        dones  = 0;
        dbzs   = 0;
        for (int i = 0; i < 200 && bus.stall_o; i++) begin
            stalls++;
            dones += int'(bus.md_done_o);
            dbzs  += int'(bus.div_by_zero_o);
            if (i + 1 == mfhi_at) drive(3'b111, 6'h10, 1'b1, 32'd0, 32'd0);
            @(negedge clk);
            #1;
        end
    endtask

    initial begin
        reset = 1'b0;
        drive(3'b000, 6'h00, 1'b0, 32'd0, 32'd0);
        #2;
        chk("rst_stall", 64'(bus.stall_o), 64'd0);
        chk("rst_hi", 64'(bus.hi_o), 64'd0);
        chk("rst_lo", 64'(bus.lo_o), 64'd0);
        chk("rst_done", 64'(bus.md_done_o), 64'd0);
        chk("rst_dbz", 64'(bus.div_by_zero_o), 64'd0);
        drive(3'b111, 6'h19, 1'b1, 32'd3, 32'd5);
        #1;
        chk("rst_start_stall", 64'(bus.stall_o), 64'd0);
        @(negedge clk);
        drive(3'b000, 6'h00, 1'b0, 32'd0, 32'd0);
        reset = 1'b1;

        dec("nor",    3'b111, 6'h27, 4'b0010);
        dec("lui",    3'b101, 6'h00, 4'b0101);
        dec("jr",     3'b111, 6'h08, 4'b1111);
        dec("lwsw",   3'b000, 6'h27, 4'b0011);
        dec("ori",    3'b001, 6'h00, 4'b0001);
        dec("andi",   3'b010, 6'h00, 4'b0000);
        dec("addi",   3'b011, 6'h00, 4'b0011);
        dec("branch", 3'b100, 6'h00, 4'b0100);
        dec("op110",  3'b110, 6'h20, 4'b1111);
        dec("add",    3'b111, 6'h20, 4'b0011);
        dec("sub",    3'b111, 6'h22, 4'b0100);
        dec("and",    3'b111, 6'h24, 4'b0000);
        dec("or",     3'b111, 6'h25, 4'b0001);
        dec("sll",    3'b111, 6'h00, 4'b0110);
        dec("srl",    3'b111, 6'h02, 4'b0111);
        dec("mfhi",   3'b111, 6'h10, 4'b1000);
        dec("mflo",   3'b111, 6'h12, 4'b1001);
        dec("fn3f",   3'b111, 6'h3F, 4'b1111);

        @(negedge clk);
        drive(3'b111, 6'h19, 1'b0, 32'd3, 32'd5);
        #1;
        chk("multu_bubble_op", 64'(bus.ALUOperation), 64'hF);
        chk("multu_bubble_stall", 64'(bus.stall_o), 64'd0);
        @(negedge clk);
        #1;
        chk("multu_bubble_nostart", 64'(bus.stall_o), 64'd0);

`ifndef ALU_SIGNED_MDU_EN
        @(negedge clk);
        drive(3'b111, 6'h1A, 1'b1, 32'd7, 32'd2);
        #1;
        chk("div_off_op", 64'(bus.ALUOperation), 64'hF);
        chk("div_off_stall", 64'(bus.stall_o), 64'd0);
        @(negedge clk);
        #1;
        chk("div_off_nostart", 64'(bus.stall_o), 64'd0);
`endif

        run_mdu("multu", 6'h19, 32'hFFFF_FFFF, 32'h0000_0002, -1);
        chk("multu_stalls", 64'(stalls), 64'd33);
        chk("multu_dones", 64'(dones), 64'd1);
        chk("multu_dbz", 64'(dbzs), 64'd0);
        chk("multu_hi", 64'(bus.hi_o), 64'h0000_0001);
        chk("multu_lo", 64'(bus.lo_o), 64'hFFFF_FFFE);

        run_mdu("divu", 6'h1B, 32'd100, 32'd7, -1);
        chk("divu_stalls", 64'(stalls), 64'd33);
        chk("divu_dones", 64'(dones), 64'd1);
        chk("divu_dbz", 64'(dbzs), 64'd0);
        chk("divu_lo", 64'(bus.lo_o), 64'd14);
        chk("divu_hi", 64'(bus.hi_o), 64'd2);

        run_mdu("div0", 6'h1B, 32'h0000_1234, 32'd0, -1);
        chk("div0_stalls", 64'(stalls), 64'd2);
        chk("div0_dones", 64'(dones), 64'd1);
        chk("div0_dbz", 64'(dbzs), 64'd1);
        chk("div0_hi", 64'(bus.hi_o), 64'h0000_1234);
        chk("div0_lo", 64'(bus.lo_o), 64'hFFFF_FFFF);

        run_mdu("hazard", 6'h19, 32'h8000_0000, 32'd4, 5);
        chk("hazard_stalls", 64'(stalls), 64'd33);
        chk("hazard_op", 64'(bus.ALUOperation), 64'h8);
        chk("hazard_hi", 64'(bus.hi_o), 64'd2);
        chk("hazard_lo", 64'(bus.lo_o), 64'd0);
        @(negedge clk);
        #1;
        chk("hazard_idle_stall", 64'(bus.stall_o), 64'd0);
        chk("hazard_hi_hold", 64'(bus.hi_o), 64'd2);

        @(negedge clk);
        drive(3'b111, 6'h1B, 1'b1, 32'd100, 32'd7);
        @(negedge clk);
        drive(3'b111, 6'h20, 1'b0, 32'd0, 32'd0);
        repeat (9) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("midrst_stall", 64'(bus.stall_o), 64'd0);
        chk("midrst_hi", 64'(bus.hi_o), 64'd0);
        chk("midrst_lo", 64'(bus.lo_o), 64'd0);
        chk("midrst_done", 64'(bus.md_done_o), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        dones = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            dones += int'(bus.md_done_o);
        end
        chk("midrst_no_done", 64'(dones), 64'd0);
        chk("midrst_idle", 64'(bus.stall_o), 64'd0);

        run_mdu("mul35", 6'h19, 32'd3, 32'd5, -1);
        chk("mul35_stalls", 64'(stalls), 64'd33);
        chk("mul35_lo", 64'(bus.lo_o), 64'd15);
        chk("mul35_hi", 64'(bus.hi_o), 64'd0);

`ifdef ALU_SIGNED_MDU_EN
        run_mdu("sdiv", 6'h1A, 32'hFFFF_FFF9, 32'd2, -1);
        chk("sdiv_stalls", 64'(stalls), 64'd33);
        chk("sdiv_lo", 64'(bus.lo_o), 64'hFFFF_FFFD);
        chk("sdiv_hi", 64'(bus.hi_o), 64'hFFFF_FFFF);
        run_mdu("smul", 6'h18, 32'hFFFF_FFFD, 32'd4, -1);
        chk("smul_hi", 64'(bus.hi_o), 64'hFFFF_FFFF);
        chk("smul_lo", 64'(bus.lo_o), 64'hFFFF_FFF4);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
